stage_wb: RTL and testbench

- Write-back stage of the 5-stage MIPS pipeline.
- Holds the MEM/WB pipeline register.
- Selects between the ALU result and load data, and aligns and extends sub-word loads.
- Drives the register-file write port of the decode stage: destination register, write data and write enable.
- Also presents the same values as a forwarding source for the hazard/forwarding unit.

---
 rtl/pipeline_pkg.sv | 26 ++
 rtl/wb_load_align.sv | 37 +++
 rtl/stage_wb.sv | 90 +++++++++
 tb/tb_stage_wb.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions for the write-back slice.
//   LS_*       : load-size encodings carried down the pipe (2'b11 is reserved, treated as word)
//   DATA_W     : datapath width (32 only)
//   REG_ADDR_W : register index width
//   mem_wb_t   : packed MEM/WB pipeline register bundle
package pipeline_pkg;

    localparam int DATA_W     = 32;
    localparam int REG_ADDR_W = 5;

    localparam logic [1:0] LS_WORD = 2'b00;
    localparam logic [1:0] LS_HALF = 2'b01;
    localparam logic [1:0] LS_BYTE = 2'b10;

    typedef struct packed {
        logic                  valid;
        logic                  regWrite;
        logic                  memToReg;
        logic [1:0]            loadSize;
        logic                  loadUnsigned;
        logic [DATA_W-1:0]     aluResult;
        logic [DATA_W-1:0]     memData;
        logic [REG_ADDR_W-1:0] rd;
    } mem_wb_t;

endpackage

// File: rtl/wb_load_align.sv
// Sub-word load alignment and extension (purely combinational).
//   rawWord    : 32-bit word read from data memory
//   addr       : low byte-address bits of the load
//   loadSize   : LS_WORD / LS_HALF / LS_BYTE (reserved code behaves as word)
//   isUnsigned : 1 = zero-extend, 0 = sign-extend
//   data       : aligned, extended result
module wb_load_align
    import pipeline_pkg::*;
(
    input  logic [31:0] rawWord,
    input  logic [1:0]  addr,
    input  logic [1:0]  loadSize,
    input  logic        isUnsigned,
    output logic [31:0] data
);

    logic [7:0]  byteLane;
    logic [15:0] halfLane;
    logic        byteSign;
    logic        halfSign;

    // Little-endian lanes; addr[0] is ignored for halfwords (no misalignment trap).
    assign byteLane = rawWord[8*addr +: 8];
    assign halfLane = rawWord[16*addr[1] +: 16];
    assign byteSign = ~isUnsigned & byteLane[7];
    assign halfSign = ~isUnsigned & halfLane[15];

    always_comb begin
        data = rawWord;
        case (loadSize)
            LS_BYTE: data = {{24{byteSign}}, byteLane};
            LS_HALF: data = {{16{halfSign}}, halfLane};
            default: data = rawWord;
        endcase
    end

endmodule

// File: rtl/stage_wb.sv
// Write-back stage: MEM/WB register, load-data/ALU select, register-file write port.
// Optional retire counter enabled by defining STAGE_WB_RETIRE_CNT_EN.
//   clk, reset        : clock, synchronous active-high reset
//   stall / flush     : hold the register / insert a bubble (reset > flush > stall)
//   in_*              : MEM stage outputs captured into MEM/WB
//   wb_rd/wb_data/wb_we : register-file write port, driven only from registered state
//   fwd_valid         : forwarding source qualifier (same as wb_we)
//   retire_count      : retired-instruction count (optional)
module stage_wb #(
    parameter int DATA_W     = pipeline_pkg::DATA_W,
    parameter int REG_ADDR_W = pipeline_pkg::REG_ADDR_W
`ifdef STAGE_WB_RETIRE_CNT_EN
    , parameter int CNT_W    = 32
`endif
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  stall,
    input  logic                  flush,
    input  logic                  in_valid,
    input  logic                  in_reg_write,
    input  logic                  in_mem_to_reg,
    input  logic [1:0]            in_load_size,
    input  logic                  in_load_unsigned,
    input  logic [DATA_W-1:0]     in_alu_result,
    input  logic [DATA_W-1:0]     in_mem_data,
    input  logic [REG_ADDR_W-1:0] in_rd,
    output logic [REG_ADDR_W-1:0] wb_rd,
    output logic [DATA_W-1:0]     wb_data,
    output logic                  wb_we,
    output logic                  fwd_valid
`ifdef STAGE_WB_RETIRE_CNT_EN
    , output logic [CNT_W-1:0]    retire_count
`endif
);

    import pipeline_pkg::*;

    mem_wb_t     memWb;
    logic [31:0] loadData;

    always_ff @(posedge clk) begin
        if (reset) begin
            memWb <= '0;
        end else if (flush) begin
            // Bubble: only the qualifiers matter, payload is left as-is.
            memWb.valid    <= 1'b0;
            memWb.regWrite <= 1'b0;
        end else if (!stall) begin
            memWb.valid        <= in_valid;
            memWb.regWrite     <= in_reg_write;
            memWb.memToReg     <= in_mem_to_reg;
            memWb.loadSize     <= in_load_size;
            memWb.loadUnsigned <= in_load_unsigned;
            memWb.aluResult    <= in_alu_result;
            memWb.memData      <= in_mem_data;
            memWb.rd           <= in_rd;
        end
    end

    wb_load_align uAlign (
        .rawWord    (memWb.memData),
        .addr       (memWb.aluResult[1:0]),
        .loadSize   (memWb.loadSize),
        .isUnsigned (memWb.loadUnsigned),
        .data       (loadData)
    );

    assign wb_rd     = memWb.rd;
    assign wb_data   = memWb.memToReg ? loadData : memWb.aluResult;
    // $0 is hardwired; never issue a write to it.
    assign wb_we     = memWb.valid & memWb.regWrite & (memWb.rd != '0);
    assign fwd_valid = wb_we;

`ifdef STAGE_WB_RETIRE_CNT_EN
    logic [CNT_W-1:0] retireCnt;

    // An instruction retires on the edge it leaves MEM/WB; a stalled one is
    // counted later when it finally moves on, so each counts exactly once.
    always_ff @(posedge clk) begin
        if (reset)
            retireCnt <= '0;
        else if (memWb.valid && !stall)
            retireCnt <= retireCnt + CNT_W'(1);
    end

    assign retire_count = retireCnt;
`endif

endmodule

// File: tb/tb_stage_wb.sv
module tb_stage_wb;

    logic        clk = 1'b0;
    logic        reset, stall, flush;
    logic        in_valid, in_reg_write, in_mem_to_reg, in_load_unsigned;
    logic [1:0]  in_load_size;
    logic [31:0] in_alu_result, in_mem_data;
    logic [4:0]  in_rd;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        wb_we, fwd_valid;
`ifdef STAGE_WB_RETIRE_CNT_EN
    logic [3:0]  retire_count;
`endif

    int checks  = 0;
    int passCnt = 0;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
        logic        we;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

`ifdef STAGE_WB_RETIRE_CNT_EN
    stage_wb #(.CNT_W(4)) dut (
`else
    stage_wb dut (
`endif
        .clk(clk), .reset(reset), .stall(stall), .flush(flush),
        .in_valid(in_valid), .in_reg_write(in_reg_write),
        .in_mem_to_reg(in_mem_to_reg), .in_load_size(in_load_size),
        .in_load_unsigned(in_load_unsigned), .in_alu_result(in_alu_result),
        .in_mem_data(in_mem_data), .in_rd(in_rd),
        .wb_rd(wb_rd), .wb_data(wb_data), .wb_we(wb_we), .fwd_valid(fwd_valid)
`ifdef STAGE_WB_RETIRE_CNT_EN
        , .retire_count(retire_count)
`endif
    );

    task automatic setIn(input logic v, input logic rw, input logic m2r,
                         input logic [1:0] sz, input logic uns,
                         input logic [31:0] alu, input logic [31:0] mem,
                         input logic [4:0] rd);
        in_valid = v; in_reg_write = rw; in_mem_to_reg = m2r;
        in_load_size = sz; in_load_unsigned = uns;
        in_alu_result = alu; in_mem_data = mem; in_rd = rd;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic cmp(input string tag, input string fld,
                       input logic [31:0] act, input logic [31:0] exp);
        checks++;
        assert (act === exp) passCnt++;
        else $error("FAIL %s.%s got=%h exp=%h", tag, fld, act, exp);
    endtask

    task automatic checkOut(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            $error("FAIL %s scoreboard empty got=none exp=entry", tag);
            return;
        end
        e = sb.pop_front();
        cmp(tag, "wb_rd",     32'(wb_rd),     32'(e.rd));
        cmp(tag, "wb_data",   wb_data,        e.data);
        cmp(tag, "wb_we",     32'(wb_we),     32'(e.we));
        cmp(tag, "fwd_valid", 32'(fwd_valid), 32'(e.we));
    endtask

    // Push the expected register-file port, clock once, compare.
    task automatic step(input string tag, input logic [4:0] rd,
                        input logic [31:0] data, input logic we);
        exp_t e;
        e.rd = rd; e.data = data; e.we = we;
        sb.push_back(e);
        tick();
        checkOut(tag);
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0; flush = 1'b0;
        setIn(1, 1, 1, 2'b10, 0, 32'hDEAD_BEEF, 32'hFFFF_FFFF, 5'd31);
        step("reset_init", 5'd0, 32'h0, 1'b0);

        // Preload then reset discards it
        reset = 1'b0;
        setIn(1, 1, 0, 2'b00, 0, 32'h0000_0055, 32'h0, 5'd5);
        step("preload", 5'd5, 32'h0000_0055, 1'b1);
        reset = 1'b1;
        step("reset_preloaded", 5'd0, 32'h0, 1'b0);
        reset = 1'b0;

        // ALU writes
        setIn(1, 1, 0, 2'b00, 0, 32'h0000_1234, 32'hCAFE_0000, 5'd8);
        step("alu_rd8", 5'd8, 32'h0000_1234, 1'b1);
        setIn(1, 1, 0, 2'b00, 0, 32'h0000_1234, 32'hCAFE_0000, 5'd0);
        step("alu_rd0", 5'd0, 32'h0000_1234, 1'b0);
        setIn(0, 1, 0, 2'b00, 0, 32'h0000_4321, 32'h0, 5'd7);
        step("invalid", 5'd7, 32'h0000_4321, 1'b0);
        setIn(1, 0, 0, 2'b00, 0, 32'h0000_0777, 32'h0, 5'd7);
        step("no_regwrite", 5'd7, 32'h0000_0777, 1'b0);

        // Byte loads
        setIn(1, 1, 1, 2'b10, 0, 32'h1000_0003, 32'h80FF_7F01, 5'd3);
        step("lb_a3", 5'd3, 32'hFFFF_FF80, 1'b1);
        setIn(1, 1, 1, 2'b10, 1, 32'h1000_0003, 32'h80FF_7F01, 5'd3);
        step("lbu_a3", 5'd3, 32'h0000_0080, 1'b1);
        setIn(1, 1, 1, 2'b10, 0, 32'h1000_0001, 32'h80FF_7F01, 5'd4);
        step("lb_a1", 5'd4, 32'h0000_007F, 1'b1);
        setIn(1, 1, 1, 2'b10, 0, 32'h1000_0002, 32'h80FF_7F01, 5'd4);
        step("lb_a2", 5'd4, 32'hFFFF_FFFF, 1'b1);
        setIn(1, 1, 1, 2'b10, 1, 32'h1000_0000, 32'h80FF_7F01, 5'd4);
        step("lbu_a0", 5'd4, 32'h0000_0001, 1'b1);

        // Halfword loads
        setIn(1, 1, 1, 2'b01, 0, 32'h2000_0002, 32'h8001_7FFE, 5'd6);
        step("lh_a2", 5'd6, 32'hFFFF_8001, 1'b1);
        setIn(1, 1, 1, 2'b01, 1, 32'h2000_0000, 32'h8001_7FFE, 5'd6);
        step("lhu_a0", 5'd6, 32'h0000_7FFE, 1'b1);
        setIn(1, 1, 1, 2'b01, 0, 32'h2000_0003, 32'h8001_7FFE, 5'd6);
        step("lh_a3", 5'd6, 32'hFFFF_8001, 1'b1);
        setIn(1, 1, 1, 2'b01, 1, 32'h2000_0002, 32'h8001_7FFE, 5'd6);
        step("lhu_a2", 5'd6, 32'h0000_8001, 1'b1);

        // Word and reserved size
        setIn(1, 1, 1, 2'b00, 0, 32'h3000_0003, 32'h8765_4321, 5'd9);
        step("lw", 5'd9, 32'h8765_4321, 1'b1);
        setIn(1, 1, 1, 2'b11, 0, 32'h3000_0001, 32'hF0E1_D2C3, 5'd9);
        step("l_reserved", 5'd9, 32'hF0E1_D2C3, 1'b1);

        // Stall holds across changing inputs
        setIn(1, 1, 0, 2'b00, 0, 32'hAAAA_0001, 32'h0, 5'd9);
        step("pre_stall", 5'd9, 32'hAAAA_0001, 1'b1);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            setIn(i[0], 1, 1, 2'b10, 0, 32'h5555_0000 + i, 32'h1234_5678, 5'(10 + i));
            step("stall_hold", 5'd9, 32'hAAAA_0001, 1'b1);
        end
        stall = 1'b0;
        setIn(1, 1, 0, 2'b00, 0, 32'h0000_0010, 32'h0, 5'd10);
        step("post_stall", 5'd10, 32'h0000_0010, 1'b1);

        // Flush wins over stall; payload held
        stall = 1'b1; flush = 1'b1;
        setIn(1, 1, 0, 2'b00, 0, 32'h0000_0011, 32'h0, 5'd11);
        step("stall_flush", 5'd10, 32'h0000_0010, 1'b0);
        stall = 1'b0;
        setIn(1, 1, 0, 2'b00, 0, 32'h0000_0013, 32'h0, 5'd13);
        step("flush_only", 5'd10, 32'h0000_0010, 1'b0);
        flush = 1'b0;
        setIn(1, 1, 0, 2'b00, 0, 32'h0000_0012, 32'h0, 5'd12);
        step("post_flush", 5'd12, 32'h0000_0012, 1'b1);

        // Reset beats stall mid-operation
        stall = 1'b1; reset = 1'b1; flush = 1'b1;
        step("reset_over_stall", 5'd0, 32'h0, 1'b0);
        stall = 1'b0; reset = 1'b0; flush = 1'b0;

`ifdef STAGE_WB_RETIRE_CNT_EN
        begin
            // V=valid instr, B=bubble, S=stall
            string ops;
            ops = "VVVSVBVVSSVVBVV";
            reset = 1'b1; tick(); reset = 1'b0;
            for (int i = 0; i < ops.len(); i++) begin
                stall = (ops[i] == "S");
                if (ops[i] != "S")
                    setIn(ops[i] == "V", 1, 0, 2'b00, 0, 32'(i), 32'h0, 5'd1);
                tick();
            end
            stall = 1'b0;
            setIn(0, 0, 0, 2'b00, 0, 32'h0, 32'h0, 5'd0);
            tick(); tick();
            cmp("retire_10", "retire_count", 32'(retire_count), 32'd10);

            reset = 1'b1; tick(); reset = 1'b0;
            cmp("retire_reset", "retire_count", 32'(retire_count), 32'd0);
            setIn(1, 1, 0, 2'b00, 0, 32'h0, 32'h0, 5'd2);
            for (int i = 0; i < 15; i++) tick();
            setIn(0, 0, 0, 2'b00, 0, 32'h0, 32'h0, 5'd0);
            tick();
            cmp("retire_max", "retire_count", 32'(retire_count), 32'd15);
            setIn(1, 1, 0, 2'b00, 0, 32'h0, 32'h0, 5'd2);
            tick();
            setIn(0, 0, 0, 2'b00, 0, 32'h0, 32'h0, 5'd0);
            tick();
            cmp("retire_wrap", "retire_count", 32'(retire_count), 32'd0);
        end
`endif

        $display("%0d/%0d checks passed", passCnt, checks);
        $finish;
    end

endmodule
